wallace_final_adder: RTL and testbench
======================================

WALLACE_FINAL_ADDER -- requirements
Module: wallace_final_adder

Interface
REQ-001 SHALL have port sys_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port sys_rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of sys_clk.
REQ-003 SHALL have port in_valid, input, 1, high when the 4:2 compressor tree presents a valid row pair.
REQ-004 SHALL have port in_ready, output, 1, high when the block accepts a row pair this cycle.
REQ-005 SHALL have port sum_row, input, 32, final sum row (d outputs) of the compressor tree.
REQ-006 SHALL have port carry_row, input, 32, final carry row (c outputs) of the compressor tree, already aligned one bit left.
REQ-007 SHALL have port out_valid, output, 1, high when product holds a valid result.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts product this cycle.
REQ-009 SHALL have port product, output, 32, signed 16x16 product, two's complement.
REQ-010 SHALL have port prod_cnt, output, 16, count of products delivered.

Function
REQ-011 SHALL compute product = (sum_row + carry_row) mod 2^32; the carry out of bit 31 is discarded.
REQ-012 SHALL transfer input when in_valid && in_ready are both high at a rising edge; sum_row/carry_row are sampled only then.
REQ-013 SHALL transfer output when out_valid && out_ready are both high at a rising edge.
REQ-014 SHALL, in two-stage mode, use stage 1 to add bits [15:0] and register the low result, the carry out of bit 15, and the upper 16 bits of both rows; stage 2 adds the upper halves plus that carry.
REQ-015 SHALL, in single-stage mode, add all 32 bits in one cycle into the output register.
REQ-016 SHALL have a latency of exactly N cycles from input transfer to out_valid with no backpressure, where N = 2 in two-stage mode and N = 1 in single-stage mode.
REQ-017 SHALL give each stage a valid bit; a stage may load when it is empty or its contents move downstream in the same cycle.
REQ-018 SHALL drive in_ready = !v1 || stage-2 load condition in two-stage mode, and in_ready = !out_valid || out_ready in single-stage mode; in_ready is combinational, with no path from in_valid.
REQ-019 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-020 SHALL hold product and out_valid stable while out_valid && !out_ready, and SHALL neither drop nor duplicate any result.
REQ-021 SHALL, when out_ready is low and the pipeline is full, deassert in_ready; no input is lost.
REQ-022 SHALL, on a simultaneous output transfer and stage advance, load the new result and keep out_valid high.
REQ-023 SHALL increment prod_cnt by 1 on each output transfer, wrapping from 16'hFFFF to 16'h0000.
REQ-024 SHALL leave product unchanged while out_valid is low; its value is don't-care.

Reset
REQ-025 SHALL, while sys_rst_n is low at a rising edge, clear all stage valid bits, out_valid, product (32'h0) and prod_cnt (16'h0).
REQ-026 SHALL drive in_ready high in the first cycle after reset release.
REQ-027 SHALL, on reset mid-operation, discard all in-flight results; no out_valid pulse follows reset.

Configuration
REQ-028 SHALL build the two-stage pipeline when macro FINAL_ADD_PIPE2_EN is defined (latency 2).
REQ-029 SHALL build the single-stage adder when FINAL_ADD_PIPE2_EN is undefined (latency 1), with identical ports and handshake rules.

Verification
REQ-030 SHALL cover a cross-half carry: sum_row=32'h0000_FFFF, carry_row=32'h0000_0001 -> product=32'h0001_0000 after N cycles.
REQ-031 SHALL cover wrap-around: sum_row=32'hFFFF_FFFF, carry_row=32'h0000_0002 -> product=32'h0000_0001, with the carry out dropped.
REQ-032 SHALL cover a signed result: rows for -300*7 (sum_row=32'hFFFF_F7CC, carry_row=32'h0) -> product=32'hFFFF_F7CC; all-zero rows -> 32'h0.
REQ-033 SHALL cover backpressure: 5 back-to-back inputs with out_ready low for 4 cycles -> in_ready drops once the pipeline is full, then all 5 products emerge in order with none lost, and prod_cnt=5.
REQ-034 SHALL cover reset mid-stream: assert sys_rst_n low with 2 results in flight -> out_valid=0, prod_cnt=0, in_ready=1 next cycle, and no stale output afterwards.
REQ-035 SHALL cover counter wrap: 65536 transfers -> prod_cnt returns to 16'h0000.

Source files
------------

// File: rtl/wallace_final_adder.sv
// -----------------------------------------------------------------------------
// wallace_final_adder
//
// Carry-propagate adder that closes a 16x16 signed Wallace/4:2 multiplier.
// It adds the final sum row and the final carry row (carry row already shifted
// one bit left) and returns the 32-bit two's-complement product. The carry out
// of bit 31 is discarded. Input and output use valid/ready handshakes.
//
// Build option:
//   FINAL_ADD_PIPE2_EN defined   -> two-stage pipeline, latency 2.
//                                   Stage 1 adds bits [15:0] and registers the
//                                   low half, the bit-15 carry and both upper
//                                   halves. Stage 2 adds the upper halves.
//   FINAL_ADD_PIPE2_EN undefined -> single 32-bit adder straight into the
//                                   output register, latency 1.
//
// Ports:
//   sys_clk    in   1   clock, rising edge
//   sys_rst_n  in   1   synchronous active-low reset
//   in_valid   in   1   row pair on sum_row/carry_row is valid
//   in_ready   out  1   row pair is accepted this cycle
//   sum_row    in  32   compressor-tree sum row
//   carry_row  in  32   compressor-tree carry row (pre-aligned)
//   out_valid  out  1   product holds a valid result
//   out_ready  in   1   consumer takes product this cycle
//   product    out 32   (sum_row + carry_row) mod 2^32
//   prod_cnt   out 16   number of delivered products, wraps
// -----------------------------------------------------------------------------
module wallace_final_adder (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] sum_row,
  input  logic [31:0] carry_row,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic [15:0] prod_cnt
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] product_q,   product_d;
  logic [15:0] prod_cnt_q,  prod_cnt_d;

  logic        in_xfer;
  logic        out_xfer;
  logic        out_load;
  logic [31:0] out_result;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

`ifdef FINAL_ADD_PIPE2_EN
  // ---------------------------------------------------------------------------
  // Stage 1: low-half add, upper halves carried forward unchanged.
  // ---------------------------------------------------------------------------
  logic        v1_q,       v1_d;
  logic [15:0] lo_q,       lo_d;
  logic        c15_q,      c15_d;
  logic [15:0] sum_hi_q,   sum_hi_d;
  logic [15:0] carry_hi_q, carry_hi_d;

  logic [16:0] lo_add;
  logic [15:0] hi_add;

  // Stage 2 (output register) loads when stage 1 holds data and the output
  // register is empty or draining this cycle.
  assign out_load = v1_q && (!out_valid_q || out_ready);
  // Stage 1 can load when empty or when its contents move on this cycle.
  assign in_ready = !v1_q || out_load;

  assign lo_add = {1'b0, sum_row[15:0]} + {1'b0, carry_row[15:0]};
  // Overflow past bit 15 of the upper add is the discarded bit-31 carry.
  assign hi_add = sum_hi_q + carry_hi_q + {15'd0, c15_q};
  assign out_result = {hi_add, lo_q};

  always_comb begin
    v1_d       = v1_q;
    lo_d       = lo_q;
    c15_d      = c15_q;
    sum_hi_d   = sum_hi_q;
    carry_hi_d = carry_hi_q;
    if (in_xfer) begin
      v1_d       = 1'b1;
      lo_d       = lo_add[15:0];
      c15_d      = lo_add[16];
      sum_hi_d   = sum_row[31:16];
      carry_hi_d = carry_row[31:16];
    end else if (out_load) begin
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      v1_q       <= 1'b0;
      lo_q       <= 16'h0;
      c15_q      <= 1'b0;
      sum_hi_q   <= 16'h0;
      carry_hi_q <= 16'h0;
    end else begin
      v1_q       <= v1_d;
      lo_q       <= lo_d;
      c15_q      <= c15_d;
      sum_hi_q   <= sum_hi_d;
      carry_hi_q <= carry_hi_d;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Single stage: full-width add straight into the output register.
  // ---------------------------------------------------------------------------
  assign in_ready   = !out_valid_q || out_ready;
  assign out_load   = in_xfer;
  assign out_result = sum_row + carry_row;
`endif

  // ---------------------------------------------------------------------------
  // Output register and delivered-product counter.
  // A load in the same cycle as an output transfer replaces the result and
  // keeps out_valid high, so back-to-back results flow at one per cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = out_valid_q;
    product_d   = product_q;
    prod_cnt_d  = prod_cnt_q;
    if (out_load) begin
      out_valid_d = 1'b1;
      product_d   = out_result;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (out_xfer) begin
      prod_cnt_d = prod_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      out_valid_q <= 1'b0;
      product_q   <= 32'h0;
      prod_cnt_q  <= 16'h0;
    end else begin
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
      prod_cnt_q  <= prod_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign prod_cnt  = prod_cnt_q;

endmodule

// File: tb/tb_wallace_final_adder.sv
module tb_wallace_final_adder;

`ifdef FINAL_ADD_PIPE2_EN
  localparam int N = 2;
`else
  localparam int N = 1;
`endif

  logic        sys_clk;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum_row;
  logic [31:0] carry_row;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic [15:0] prod_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_exp = 0;

  wallace_final_adder dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_row   (sum_row),
    .carry_row (carry_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .prod_cnt  (prod_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated transfer with out_ready high: checks latency, value, count.
  task automatic single(input string tag, input logic [31:0] s, input logic [31:0] c,
                        input logic [31:0] exp);
    int lat;
    @(negedge sys_clk);
    in_valid  = 1'b1;
    sum_row   = s;
    carry_row = c;
    out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge sys_clk);
    lat = 0;
    do begin
      @(negedge sys_clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 8);
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_product"}, product, exp);
    cnt_exp++;
    @(negedge sys_clk);
    chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, prod_cnt}, cnt_exp);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cnt_exp   = 0;
  endtask

  logic [31:0] bp_s   [5] = '{32'h0000_0001, 32'h0000_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_0000};
  logic [31:0] bp_c   [5] = '{32'h0000_0001, 32'h0000_0003, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_5678};
  logic [31:0] bp_exp [5] = '{32'h0000_0002, 32'h0001_0002, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678};

  initial begin
    int idx;
    int rx;
    int cyc;
    bit acc;
    bit del;
    bit seen;

    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_row   = 32'h0;
    carry_row = 32'h0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_product",   product, 32'h0);
    chk("rst_prod_cnt",  {16'd0, prod_cnt}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

    // Directed arithmetic vectors
    single("cross_half", 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000);
    single("wrap",       32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    single("signed",     32'hFFFF_F7CC, 32'h0000_0000, 32'hFFFF_F7CC);
    single("zero",       32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    single("mixed",      32'h1234_5678, 32'h0F0F_0F0F, 32'h2143_6587);
    single("hi_carry",   32'h7FFF_8000, 32'h0000_8000, 32'h8000_0000);

    // Backpressure: 5 back-to-back inputs, out_ready low for 4 cycles
    do_reset();
    idx = 0; rx = 0; cyc = 0;
    while (rx < 5 && cyc < 60) begin
      @(negedge sys_clk);
      out_ready = (cyc >= 4);
      in_valid  = (idx < 5);
      sum_row   = bp_s[idx < 5 ? idx : 0];
      carry_row = bp_c[idx < 5 ? idx : 0];
      #1;
      if (cyc == 0) chk("bp_ready_start", {31'd0, in_ready}, 32'd1);
      if (cyc == 3) chk("bp_ready_full",  {31'd0, in_ready}, 32'd0);
      if (out_valid) chk($sformatf("bp_product_%0d", rx), product, bp_exp[rx]);
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      @(posedge sys_clk);
      if (acc) idx++;
      if (del) rx++;
      cyc++;
    end
    in_valid = 1'b0;
    @(negedge sys_clk);
    chk("bp_delivered", rx, 32'd5);
    chk("bp_prod_cnt",  {16'd0, prod_cnt}, 32'd5);
    chk("bp_ov_idle",   {31'd0, out_valid}, 32'd0);

    // Reset with results in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sum_row   = 32'h1111_1111;
    carry_row = 32'h0000_0001;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sum_row = 32'h2222_2222;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("mid_inflight", {31'd0, out_valid}, 32'd1);
    in_valid  = 1'b0;
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_prod_cnt",  {16'd0, prod_cnt}, 32'd0);
    chk("mid_product",   product, 32'h0);
    sys_rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge sys_clk);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      chk($sformatf("mid_no_stale_%0d", i), {31'd0, out_valid}, 32'd0);
    end

    // Counter wrap with sustained one-per-cycle throughput
    idx = 0; rx = 0; cyc = 0; seen = 1'b0;
    out_ready = 1'b1;
    while (rx < 65536 && cyc < 70000) begin
      @(negedge sys_clk);
      if (rx == 65535 && !seen) begin
        chk("wrap_cnt_ffff", {16'd0, prod_cnt}, 32'h0000_FFFF);
        seen = 1'b1;
      end
      in_valid  = (idx < 65536);
      sum_row   = idx;
      carry_row = 32'h0;
      #1;
      if (out_valid) chk("wrap_product", product, rx);
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      @(posedge sys_clk);
      if (acc) idx++;
      if (del) rx++;
      cyc++;
    end
    in_valid = 1'b0;
    @(negedge sys_clk);
    chk("wrap_delivered", rx, 32'd65536);
    chk("wrap_cnt_zero",  {16'd0, prod_cnt}, 32'h0);
    chk("wrap_cycles",    cyc, 65536 + N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
